// File: rtl/lcd_sequencer.sv
// HD44780 write sequencer for a Nios II custom-instruction port: power-up wait,
// fixed init commands, then one timed LCD write per start pulse with a done strobe.
//
// state     | meaning
// PWR_WAIT  | post-reset settling delay before any LCD access
// INIT_LOAD | fetch the next init command from the ROM
// SETUP     | RS/data driven, E low, address setup time
// PULSE     | E high
// HOLD      | E low, RS/data held
// EXEC      | LCD busy executing the command (long wait for clear/home)
// DONE      | one-cycle completion strobe for a CPU write
// IDLE      | ready for the next CPU write
module lcd_sequencer #(
    parameter int SETUP_CYC     = 3,
    parameter int EN_CYC        = 25,
    parameter int HOLD_CYC      = 3,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int POWERUP_CYC   = 750000,
    parameter int CNT_W         = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result,
    output logic        ready,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, DONE, IDLE
    } state_t;

    // A zero-length phase behaves as a one-cycle phase.
    function automatic logic [CNT_W-1:0] load_val(input int cyc);
        return (cyc > 1) ? CNT_W'(cyc - 1) : '0;
    endfunction

    function automatic logic [7:0] init_rom(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    localparam logic [CNT_W-1:0] SETUP_LD = load_val(SETUP_CYC);
    localparam logic [CNT_W-1:0] EN_LD    = load_val(EN_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = load_val(HOLD_CYC);
    localparam logic [CNT_W-1:0] EXEC_LD  = load_val(EXEC_CYC);
    localparam logic [CNT_W-1:0] LONG_LD  = load_val(LONG_EXEC_CYC);
    localparam logic [CNT_W-1:0] PWR_LD   = load_val(POWERUP_CYC);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [1:0]       idx;
    logic             armed;
    logic             is_init;
    logic             pending;
    logic [9:0]       req_word;
    logic             cpu_busy;
    logic             long_cmd;
    logic [9:0]       next_req;
    logic             unused_dataa;

    assign unused_dataa = ^dataa[31:10];
    assign lcd_rw       = 1'b0;
    assign result       = {22'b0, req_word};
    assign cpu_busy     = !is_init && (state inside {SETUP, PULSE, HOLD, EXEC, DONE});
    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign long_cmd     = !lcd_rs && (lcd_data[7:2] == 6'd0);
    assign next_req     = pending ? req_word : dataa[9:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= PWR_WAIT;
            timer    <= '0;
            idx      <= 2'd0;
            armed    <= 1'b0;
            is_init  <= 1'b1;
            pending  <= 1'b0;
            req_word <= 10'd0;
            done     <= 1'b0;
            ready    <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'd0;
        end else begin
            done <= 1'b0;
            if (timer != '0)
                timer <= timer - CNT_W'(1);
            if (start && !pending && state != IDLE && !cpu_busy) begin
                pending  <= 1'b1;
                req_word <= dataa[9:0];
            end
            case (state)
                PWR_WAIT: begin
                    // Reset leaves the timer at zero, so the first cycle arms it.
                    if (!armed) begin
                        armed <= 1'b1;
                        if (PWR_LD == '0)
                            state <= INIT_LOAD;
                        else
                            timer <= PWR_LD - CNT_W'(1);
                    end else if (timer == '0) begin
                        state <= INIT_LOAD;
                    end
                end
                INIT_LOAD: begin
                    is_init  <= 1'b1;
                    lcd_rs   <= 1'b0;
                    lcd_data <= init_rom(idx);
                    timer    <= SETUP_LD;
                    state    <= SETUP;
                end
                SETUP: if (timer == '0) begin
                    lcd_en <= 1'b1;
                    timer  <= EN_LD;
                    state  <= PULSE;
                end
                PULSE: if (timer == '0) begin
                    lcd_en <= 1'b0;
                    timer  <= HOLD_LD;
                    state  <= HOLD;
                end
                HOLD: if (timer == '0) begin
                    timer <= long_cmd ? LONG_LD : EXEC_LD;
                    state <= EXEC;
                end
                EXEC: if (timer == '0) begin
                    if (is_init) begin
                        idx <= idx + 2'd1;
                        if (idx != 2'd3) begin
                            state <= INIT_LOAD;
                        end else if (pending || start) begin
                            // A request queued during init runs without showing ready.
                            pending  <= 1'b0;
                            is_init  <= 1'b0;
                            req_word <= next_req;
                            lcd_rs   <= next_req[9];
                            lcd_data <= next_req[7:0];
                            timer    <= SETUP_LD;
                            state    <= SETUP;
                        end else begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                IDLE: if (start) begin
                    ready    <= 1'b0;
                    is_init  <= 1'b0;
                    req_word <= dataa[9:0];
                    lcd_rs   <= dataa[9];
                    lcd_data <= dataa[7:0];
                    timer    <= SETUP_LD;
                    state    <= SETUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed self-checking bench for lcd_sequencer with shortened timing parameters.
module tb_lcd_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;
    logic        ready;
    logic        lcd_en;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    lcd_sequencer #(
        .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(2), .EXEC_CYC(10),
        .LONG_EXEC_CYC(30), .POWERUP_CYC(50), .CNT_W(20)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dataa(dataa),
        .done(done), .result(result), .ready(ready), .lcd_en(lcd_en),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          rise_cnt = 0;
    int          last_rise_cyc = 0;
    int          last_fall_cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    int          ready_hi_cnt = 0;
    int          ks = 0;
    int          rel_cyc = 0;
    int          e4 = 0;
    int          e5 = 0;
    logic [7:0]  last_rise_data = 8'd0;
    logic        last_rise_rs = 1'b0;
    logic        en_prev = 1'b0;
    logic        rw_bad = 1'b0;
    logic [31:0] last_result = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (lcd_en && !en_prev) begin
            rise_cnt++;
            last_rise_cyc  = cyc;
            last_rise_data = lcd_data;
            last_rise_rs   = lcd_rs;
        end
        if (!lcd_en && en_prev) last_fall_cyc = cyc;
        en_prev = lcd_en;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_result   = result;
        end
        if (ready) ready_hi_cnt++;
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
    endtask

    task automatic wait_rise(input string tag, input int bound);
        int target = rise_cnt + 1;
        int n = 0;
        while (rise_cnt < target && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(rise_cnt >= target), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int bound);
        int target = done_cnt + 1;
        int n = 0;
        while (done_cnt < target && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_ready(input string tag, input int bound);
        int n = 0;
        while (ready !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(ready), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic do_start(input logic [31:0] d);
        start = 1'b1;
        dataa = d;
        tick();
        start = 1'b0;
        dataa = 32'd0;
        ks    = cyc;
    endtask

    // Expected init timing: 50 power-up + 1 load + 2 setup before the first E.
    task automatic check_init(input string tag);
        wait_rise({tag, "_r1"}, 100);
        check({tag, "_r1_time"}, 32'(last_rise_cyc - rel_cyc), 32'd53);
        check({tag, "_r1_data"}, 32'(last_rise_data), 32'h38);
        check({tag, "_r1_rs"}, 32'(last_rise_rs), 32'd0);
        wait_rise({tag, "_r2"}, 40);
        check({tag, "_r2_data"}, 32'(last_rise_data), 32'h0C);
        wait_rise({tag, "_r3"}, 40);
        check({tag, "_r3_data"}, 32'(last_rise_data), 32'h06);
        wait_rise({tag, "_r4"}, 40);
        check({tag, "_r4_data"}, 32'(last_rise_data), 32'h01);
        check({tag, "_r4_rs"}, 32'(last_rise_rs), 32'd0);
        e4 = last_rise_cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        dataa   = 32'd0;
        tick();
        tick();
        check("rst_en", 32'(lcd_en), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        check("rst_data", 32'(lcd_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_result", result, 32'd0);

        // 1: power-up and init with no CPU traffic
        do_reset();
        repeat (50) tick();
        check("t1_quiet_pwr", 32'(rise_cnt), 32'd0);
        check_init("t1");
        wait_ready("t1_ready", 60);
        check("t1_en_width", 32'(last_fall_cyc - e4), 32'd4);
        check("t1_ready_time", 32'(cyc - e4), 32'd36);
        check("t1_no_done", 32'(done_cnt), 32'd0);

        // 2: data write 'A'
        do_start(32'h241);
        check("t2_ready_low", 32'(ready), 32'd0);
        check("t2_setup_rs", 32'(lcd_rs), 32'd1);
        check("t2_setup_data", 32'(lcd_data), 32'h41);
        check("t2_setup_en", 32'(lcd_en), 32'd0);
        tick();
        check("t2_setup2_en", 32'(lcd_en), 32'd0);
        wait_rise("t2_rise", 10);
        check("t2_rise_time", 32'(last_rise_cyc - ks), 32'd2);
        check("t2_rise_data", 32'(last_rise_data), 32'h41);
        wait_done("t2_done", 40);
        check("t2_en_width", 32'(last_fall_cyc - last_rise_cyc), 32'd4);
        check("t2_done_time", 32'(last_done_cyc - ks), 32'd18);
        check("t2_result", last_result, 32'h241);
        tick();
        check("t2_done_single", 32'(done), 32'd0);
        check("t2_ready_back", 32'(ready), 32'd1);

        // 3: clear takes the long wait; 0x80 does not
        do_start(32'h001);
        wait_done("t3a_done", 60);
        check("t3a_done_time", 32'(last_done_cyc - ks), 32'd38);
        check("t3a_result", last_result, 32'h001);
        tick();
        do_start(32'h080);
        wait_done("t3b_done", 60);
        check("t3b_done_time", 32'(last_done_cyc - ks), 32'd18);
        tick();

        // 4: request posted during the power-up wait
        do_reset();
        done_cnt     = 0;
        ready_hi_cnt = 0;
        repeat (5) tick();
        start = 1'b1;
        dataa = 32'h242;
        tick();
        start = 1'b0;
        dataa = 32'd0;
        check_init("t4");
        wait_rise("t4_r5", 60);
        e5 = last_rise_cyc;
        check("t4_r5_time", 32'(e5 - e4), 32'd38);
        check("t4_r5_data", 32'(last_rise_data), 32'h42);
        check("t4_r5_rs", 32'(last_rise_rs), 32'd1);
        wait_done("t4_done", 40);
        check("t4_done_time", 32'(last_done_cyc - e5), 32'd16);
        check("t4_result", last_result, 32'h242);
        check("t4_no_early_ready", 32'(ready_hi_cnt), 32'd0);
        tick();
        check("t4_ready_after", 32'(ready), 32'd1);
        repeat (20) tick();
        check("t4_one_done", 32'(done_cnt), 32'd1);

        // 5: reset while E is high during a CPU write
        do_start(32'h245);
        wait_rise("t5_rise", 10);
        tick();
        check("t5_en_high", 32'(lcd_en), 32'd1);
        reset_n = 1'b0;
        done_cnt = 0;
        #1;
        check("t5_rst_en", 32'(lcd_en), 32'd0);
        check("t5_rst_rs", 32'(lcd_rs), 32'd0);
        check("t5_rst_data", 32'(lcd_data), 32'd0);
        check("t5_rst_ready", 32'(ready), 32'd0);
        check("t5_rst_result", result, 32'd0);
        do_reset();
        check_init("t5");
        wait_ready("t5_ready", 60);
        check("t5_no_done", 32'(done_cnt), 32'd0);

        // 6: RW requested by the CPU is ignored
        do_start(32'h343);
        check("t6_rs", 32'(lcd_rs), 32'd1);
        check("t6_data", 32'(lcd_data), 32'h43);
        wait_done("t6_done", 40);
        check("t6_done_time", 32'(last_done_cyc - ks), 32'd18);
        check("t6_result", last_result, 32'h343);
        check("t6_rw_never", 32'(rw_bad), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
